dmem_interface: RTL and testbench
=================================

DMEM_INTERFACE -- requirements
Module: dmem_interface

Interface
REQ-001 SHALL have parameter DEPTH, default 4, store-buffer entries; power of two, >=2.
REQ-002 SHALL have parameter AW, default 32, address and data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  datapath load request this cycle.
REQ-006 mem_write  input  1  datapath store request this cycle.
REQ-007 addr  input  AW  byte address from ALU result; word granular, addr[1:0] ignored.
REQ-008 wdata  input  AW  store data from register file port 2.
REQ-009 readdata  output  AW  load result to the result mux.
REQ-010 stall  output  1  high means the datapath SHALL hold PC and suppress register write.
REQ-011 mem_req, mem_we  output  1 each  backing-memory request and write-enable.
REQ-012 mem_addr, mem_wdata  output  AW each  backing-memory address and data.
REQ-013 mem_ack  input  1  backing memory accepts/completes the request this cycle.
REQ-014 mem_rdata  input  AW  read data, valid with mem_ack on a read.
REQ-015 sb_count  output  clog2(DEPTH)+1  occupied entries; sb_empty  output  1  sb_count==0.

Function
REQ-016 Store (mem_write=1), buffer not full: enqueue {addr[AW-1:2], wdata} at tail that edge; stall=0.
REQ-017 Store with buffer full: stall=1 until the edge after an entry is popped; a pop in the same cycle SHALL NOT relieve stall.
REQ-018 Stores to an already-buffered word SHALL append a new entry; no merging.
REQ-019 Load hit (addr[AW-1:2] matches any valid entry): readdata = youngest matching entry's data, combinationally; stall=0.
REQ-020 Load miss: stall=1; after the read ack, rdata register captures mem_rdata; next cycle stall=0 and readdata=rdata register; flag clears on that edge.
REQ-021 mem_read and mem_write both high: treated as store only; read ignored.
REQ-022 FSM states IDLE, WRITE, READ; reset state IDLE.
REQ-023 IDLE -> READ when a load miss is pending and not yet done (priority over draining); IDLE -> WRITE when buffer non-empty and no pending miss; else stay.
REQ-024 WRITE: mem_req=1, mem_we=1, mem_addr={head word,2'b00}, mem_wdata=head data, held stable; on mem_ack pop head, -> IDLE.
REQ-025 READ: mem_req=1, mem_we=0, mem_addr={addr word,2'b00}, held stable; on mem_ack capture data, -> IDLE.
REQ-026 Transactions SHALL NOT be aborted; one transaction per mem_ack; mem_ack in IDLE ignored.
REQ-027 Head entry stays valid and forwardable until its write ack.
REQ-028 Pointers wrap modulo DEPTH; simultaneous enqueue and pop SHALL leave sb_count unchanged.
REQ-029 In IDLE mem_req=0; mem_addr/mem_wdata SHALL be 0 when mem_req=0.

Reset
REQ-030 reset low SHALL asynchronously clear: all entries invalid, pointers 0, sb_count=0, sb_empty=1, FSM IDLE, mem_req=0, mem_we=0, rdata register 0, load-done flag 0; readdata=0 when no hit.
REQ-031 Reset mid-transaction SHALL abandon it; buffered stores are lost; a subsequent mem_ack SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold FSM state type, DEPTH default, AW default, word-index width.
REQ-033 Storage and pointers SHALL be one sub-module sb_fifo (push, pop, full, empty, count, per-entry CAM match output); arbitration/FSM in dmem_interface.

Verification
REQ-034 Store 0x10<-0xAAAA_0001, mem_ack held 0: stall=0, sb_count=1, mem_req=1, mem_we=1, mem_addr=0x10.
REQ-035 Stores 0x20<-1 then 0x20<-2, load 0x20 same-or-next cycle: readdata=2, stall=0.
REQ-036 Five stores, mem_ack=0: fifth cycle stall=1, sb_count=4; ack once -> pop; next edge fifth store enqueued, stall=0.
REQ-037 Load 0x40 miss, buffer empty, mem_ack after 3 cycles with mem_rdata=0xDEAD_BEEF: stall=1 for 4 cycles, then readdata=0xDEAD_BEEF, stall=0.
REQ-038 Load miss with 2 buffered stores: current write completes, then READ before remaining drain; sb_count 2->1 then READ.
REQ-039 Assert reset during READ with mem_ack arriving after release: FSM IDLE, mem_req=0, sb_count=0, ack ignored.

Source files
------------

// File: rtl/dmem_interface_pkg.sv
// Shared types and defaults for the data-memory interface and its store buffer.
package dmem_interface_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int AW_DEF    = 32;
  localparam int WIDX_W    = AW_DEF - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  function automatic int word_w(input int aw);
    return aw - 2;
  endfunction

endpackage

// File: rtl/dmem_interface_sb_fifo.sv
// Store-buffer storage: circular FIFO of {word, data} with a per-entry CAM match
// against a lookup word. Head stays valid until popped.
module sb_fifo #(
  parameter int DEPTH = 4,
  parameter int WW    = 30,
  parameter int DW    = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_push,
  input  logic [WW-1:0]                  i_push_word,
  input  logic [DW-1:0]                  i_push_data,
  input  logic                           i_pop,
  input  logic [WW-1:0]                  i_cam_word,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic [$clog2(DEPTH)-1:0]       o_head_idx,
  output logic [WW-1:0]                  o_head_word,
  output logic [DW-1:0]                  o_head_data,
  output logic [DEPTH-1:0]               o_match,
  output logic [DEPTH-1:0][DW-1:0]       o_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][WW-1:0] r_word;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW:0]              r_count;
  logic                     w_push;
  logic                     w_pop;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push & ~o_full;
  assign w_pop    = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word   <= '0;
      r_data   <= '0;
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + PW'(1);
      end
      // Push after pop: the two slots can only coincide when empty or full.
      if (w_push) begin
        r_vld[r_wr_ptr]  <= 1'b1;
        r_word[r_wr_ptr] <= i_push_word;
        r_data[r_wr_ptr] <= i_push_data;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cam
    assign o_match[g] = r_vld[g] && (r_word[g] == i_cam_word);
  end

  assign o_count     = r_count;
  assign o_head_idx  = r_rd_ptr;
  assign o_head_word = r_word[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];
  assign o_data      = r_data;

endmodule

// File: rtl/dmem_interface.sv
// Datapath-to-memory interface: posted store buffer with load forwarding,
// blocking load misses, single-outstanding backing-memory transactions.
module dmem_interface
  import dmem_interface_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [AW-1:0]           addr,
  input  logic [AW-1:0]           wdata,
  output logic [AW-1:0]           readdata,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [AW-1:0]           mem_wdata,
  input  logic                    mem_ack,
  input  logic [AW-1:0]           mem_rdata,
  output logic [$clog2(DEPTH):0]  sb_count,
  output logic                    sb_empty
);

  localparam int WW = AW - 2;
  localparam int PW = $clog2(DEPTH);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [WW-1:0]           r_rd_word;
  logic [AW-1:0]           r_rdata;
  logic                    r_ld_done;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_load;
  logic                    w_hit;
  logic                    w_miss_pend;
  logic                    w_rd_ack;
  logic [DEPTH-1:0]        w_match;
  logic [DEPTH-1:0][AW-1:0] w_ent_data;
  logic [PW-1:0]           w_head_idx;
  logic [WW-1:0]           w_head_word;
  logic [AW-1:0]           w_head_data;
  logic [AW-1:0]           w_hit_data;
  logic                    w_unused_addr;

  assign w_unused_addr = &{1'b0, addr[1:0]};

  // A simultaneous read+write is a store; the read side is dropped.
  assign w_load   = mem_read & ~mem_write;
  assign w_push   = mem_write & ~w_full;
  assign w_pop    = (r_state == WRITE) & mem_ack;
  assign w_rd_ack = (r_state == READ) & mem_ack;

  sb_fifo #(
    .DEPTH (DEPTH),
    .WW    (WW),
    .DW    (AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_word (addr[AW-1:2]),
    .i_push_data (wdata),
    .i_pop       (w_pop),
    .i_cam_word  (addr[AW-1:2]),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (sb_count),
    .o_head_idx  (w_head_idx),
    .o_head_word (w_head_word),
    .o_head_data (w_head_data),
    .o_match     (w_match),
    .o_data      (w_ent_data)
  );

  // Walk from oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] v_idx;
    v_idx      = '0;
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = w_head_idx + PW'(k);
      if (w_match[v_idx]) begin
        w_hit      = 1'b1;
        w_hit_data = w_ent_data[v_idx];
      end
    end
  end

  assign w_miss_pend = w_load & ~w_hit & ~r_ld_done;
  // Fullness is the registered count, so a pop this cycle cannot admit a store.
  assign stall       = (mem_write & w_full) | w_miss_pend;
  assign readdata    = w_hit ? w_hit_data : r_rdata;
  assign sb_empty    = w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rd_word <= '0;
      r_rdata   <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ld_done <= w_rd_ack;
      if (r_state == IDLE && w_miss_pend) r_rd_word <= addr[AW-1:2];
      if (w_rd_ack) r_rdata <= mem_rdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_miss_pend)   w_state_nxt = READ;
        else if (!w_empty) w_state_nxt = WRITE;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_head_word, 2'b00};
        mem_wdata = w_head_data;
        if (mem_ack) w_state_nxt = IDLE;
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = {r_rd_word, 2'b00};
        if (mem_ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_interface.sv
// Scoreboarded bench: expected memory writes and load results are queued at
// drive time and retired when the DUT performs them.
module tb_dmem_interface;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] readdata, mem_addr, mem_wdata;
  logic        stall, mem_req, mem_we, sb_empty;
  logic [2:0]  sb_count;

  int          n_chk  = 0;
  int          n_fail = 0;
  wr_t         wq[$];
  logic [31:0] rq[$];

  always #5 clk = ~clk;

  dmem_interface #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .readdata  (readdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .sb_count  (sb_count),
    .sb_empty  (sb_empty)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    mem_write = 1'b1;
    mem_read  = 1'b0;
    addr      = a;
    wdata     = d;
    e.a       = a;
    e.d       = d;
    wq.push_back(e);
  endtask

  task automatic ld(input logic [31:0] a);
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = a;
  endtask

  task automatic idle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 64) begin
      tick();
      idle();
      mem_ack = mem_req;
      @(negedge clk);
      if (sb_empty && !mem_req) break;
      n++;
    end
    mem_ack = 1'b0;
    chk("drain_empty", {31'd0, sb_empty}, 32'd1);
    chk("drain_wq", wq.size(), 32'd0);
  endtask

  // Memory-side monitor: every accepted write must match the oldest queued store.
  always @(negedge clk) begin
    if (rst_n && mem_req && mem_we && mem_ack) begin
      chk("wq_nonempty", {31'd0, wq.size() != 0}, 32'd1);
      if (wq.size() != 0) begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_wdata, e.d);
      end
    end
  end

  // Load completion monitor: a non-stalled load retires the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && mem_read && !mem_write && !stall) begin
      chk("rq_nonempty", {31'd0, rq.size() != 0}, 32'd1);
      if (rq.size() != 0) chk("ld_data", readdata, rq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_ack = 1'b0;
    addr = '0; wdata = '0; mem_rdata = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_count", {29'd0, sb_count}, 32'd0);
    chk("rst_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single posted store, memory not acking
    tick(); st(32'h10, 32'hAAAA_0001);
    @(negedge clk); chk("A_stall", {31'd0, stall}, 32'd0);
    tick(); idle();
    @(negedge clk); chk("A_count", {29'd0, sb_count}, 32'd1);
    tick();
    @(negedge clk);
    chk("A_req",  {31'd0, mem_req}, 32'd1);
    chk("A_we",   {31'd0, mem_we}, 32'd1);
    chk("A_addr", mem_addr, 32'h10);
    chk("A_wd",   mem_wdata, 32'hAAAA_0001);
    tick(); mem_ack = 1'b1;
    @(negedge clk);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("A_count0", {29'd0, sb_count}, 32'd0);
    chk("A_req0",   {31'd0, mem_req}, 32'd0);
    chk("A_addr0",  mem_addr, 32'd0);

    // Two stores to one word, then forward the youngest
    tick(); st(32'h20, 32'd1);
    tick(); st(32'h20, 32'd2);
    tick(); ld(32'h20); rq.push_back(32'd2);
    @(negedge clk);
    chk("B_stall", {31'd0, stall}, 32'd0);
    chk("B_count", {29'd0, sb_count}, 32'd2);
    drain();

    // Fill the buffer; fifth store stalls until after the pop edge
    for (int i = 0; i < 4; i++) begin
      tick(); st(32'h100 + 32'(i * 4), 32'h5000 + 32'(i));
      @(negedge clk); chk("C_fill_stall", {31'd0, stall}, 32'd0);
    end
    tick(); st(32'h110, 32'h5004);
    @(negedge clk);
    chk("C_full_stall", {31'd0, stall}, 32'd1);
    chk("C_full_count", {29'd0, sb_count}, 32'd4);
    tick();
    @(negedge clk); chk("C_hold_stall", {31'd0, stall}, 32'd1);
    tick(); mem_ack = 1'b1;
    @(negedge clk); chk("C_popcyc_stall", {31'd0, stall}, 32'd1);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("C_after_stall", {31'd0, stall}, 32'd0);
    chk("C_after_count", {29'd0, sb_count}, 32'd3);
    tick(); idle();
    @(negedge clk); chk("C_refill_count", {29'd0, sb_count}, 32'd4);
    drain();

    // Enqueue and pop on the same edge
    tick(); st(32'h200, 32'hA);
    tick(); idle();
    tick(); st(32'h204, 32'hB); mem_ack = 1'b1;
    @(negedge clk); chk("D_stall", {31'd0, stall}, 32'd0);
    tick(); idle(); mem_ack = 1'b0;
    @(negedge clk); chk("D_count", {29'd0, sb_count}, 32'd1);
    drain();

    // Load miss on empty buffer, ack on the fourth stalled cycle
    tick(); ld(32'h40); rq.push_back(32'hDEAD_BEEF);
    @(negedge clk); chk("E_stall0", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("E_stall1", {31'd0, stall}, 32'd1);
    chk("E_req",    {31'd0, mem_req}, 32'd1);
    chk("E_we",     {31'd0, mem_we}, 32'd0);
    chk("E_addr",   mem_addr, 32'h40);
    tick();
    @(negedge clk); chk("E_stall2", {31'd0, stall}, 32'd1);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("E_stall3", {31'd0, stall}, 32'd1);
    tick(); mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
    @(negedge clk); chk("E_done_stall", {31'd0, stall}, 32'd0);
    tick(); idle();
    @(negedge clk); chk("E_req_idle", {31'd0, mem_req}, 32'd0);

    // Load miss behind two stores: current write finishes, then READ
    tick(); st(32'h300, 32'd11);
    tick(); st(32'h304, 32'd22);
    tick(); ld(32'h400); rq.push_back(32'd55);
    @(negedge clk);
    chk("F_stall", {31'd0, stall}, 32'd1);
    chk("F_count2", {29'd0, sb_count}, 32'd2);
    chk("F_we", {31'd0, mem_we}, 32'd1);
    tick(); mem_ack = 1'b1;
    @(negedge clk);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("F_count1", {29'd0, sb_count}, 32'd1);
    chk("F_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    @(negedge clk);
    chk("F_rd_req",  {31'd0, mem_req}, 32'd1);
    chk("F_rd_we",   {31'd0, mem_we}, 32'd0);
    chk("F_rd_addr", mem_addr, 32'h400);
    chk("F_rd_cnt",  {29'd0, sb_count}, 32'd1);
    tick(); mem_ack = 1'b1; mem_rdata = 32'd55;
    tick(); mem_ack = 1'b0; mem_rdata = 32'd0;
    @(negedge clk);
    drain();

    // Reset while READ is outstanding with a store still buffered
    tick(); st(32'h500, 32'd7);
    tick(); st(32'h504, 32'd8);
    tick(); ld(32'h600);
    tick(); mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick();
    @(negedge clk);
    chk("G_rd_req", {31'd0, mem_req}, 32'd1);
    chk("G_rd_we",  {31'd0, mem_we}, 32'd0);
    chk("G_rd_cnt", {29'd0, sb_count}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("G_async_req", {31'd0, mem_req}, 32'd0);
    chk("G_async_cnt", {29'd0, sb_count}, 32'd0);
    chk("G_async_emp", {31'd0, sb_empty}, 32'd1);
    wq.delete();
    rq.delete();
    mem_read = 1'b0;
    tick(); rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(negedge clk); chk("G_ack_req", {31'd0, mem_req}, 32'd0);
    tick(); mem_ack = 1'b0;
    @(negedge clk);
    chk("G_post_req",  {31'd0, mem_req}, 32'd0);
    chk("G_post_cnt",  {29'd0, sb_count}, 32'd0);
    chk("G_post_rd",   readdata, 32'd0);

    // Read and write together is a store; then forward from the head entry
    tick(); st(32'h800, 32'h99); mem_read = 1'b1;
    @(negedge clk); chk("H_stall", {31'd0, stall}, 32'd0);
    tick(); idle();
    @(negedge clk); chk("H_count", {29'd0, sb_count}, 32'd1);
    tick(); ld(32'h800); rq.push_back(32'h99);
    @(negedge clk); chk("H_head_req", {31'd0, mem_req}, 32'd1);
    drain();
    chk("rq_left", rq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
